l2_cache_control: RTL and testbench
===================================

# l2_cache_control

Control FSM for the 2-way, 64-set, 256-bit-line L2 cache. It sequences the per-way data, tag, valid, dirty and LRU arrays, and serves line-sized requests from the L1 arbiter. On a miss it writes back the dirty victim, fetches the line from physical memory, then re-checks. It is pure control: tag compare results arrive as inputs, and the block drives array load enables and datapath mux selects.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating hit and miss counters.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `mem_read`  in  1  upstream line read request; held until `mem_resp`.
- `mem_write`  in  1  upstream full-line write request; held until `mem_resp`.
- `mem_resp`  out  1  one-cycle pulse; request complete.
- `hit0`, `hit1`  in  1 each  way tag match AND valid, for the current index.
- `dirty0`, `dirty1`  in  1 each  way dirty bits, current index.
- `lru`  in  1  least-recently-used way, current index.
- `pmem_resp`  in  1  physical memory done pulse.
- `pmem_read`, `pmem_write`  out  1 each  physical memory requests; held until `pmem_resp`.
- `load_data0`, `load_data1`  out  1 each  data array write enables.
- `load_tag0`, `load_tag1`  out  1 each  tag array write enables.
- `load_valid0`, `load_valid1`  out  1 each  valid array write enables; valid_in is always 1.
- `load_dirty0`, `load_dirty1`  out  1 each  dirty array write enables.
- `dirty_in`  out  1  value written to the dirty array.
- `load_lru`  out  1  LRU array write enable.
- `lru_in`  out  1  value written to the LRU array.
- `data_sel`  out  1  data array source: 0 = upstream wdata, 1 = pmem rdata.
- `way_sel`  out  1  way driven onto upstream rdata and writeback data.
- `pmem_addr_sel`  out  1  physical memory address source: 0 = request address, 1 = victim {tag, index}.
- `hit_count`, `miss_count`  out  `CNT_W` each  saturating performance counters.

## Operation
States are IDLE, COMPARE, WRITEBACK and FETCH. All outputs are combinational from state and inputs, except the counters.

- **IDLE**
  - All outputs are 0.
  - If `mem_read` or `mem_write` is asserted, go to COMPARE.
- **COMPARE, hit** (`hit0` or `hit1`; if both are set, way 0 wins)
  - Assert `mem_resp` and set `way_sel` to the hit way.
  - Assert `load_lru` with `lru_in` = NOT the hit way.
  - On a write hit, also assert `load_data<hit>` with `data_sel`=0, and `load_dirty<hit>` with `dirty_in`=1.
  - Increment `hit_count`, unless this COMPARE was re-entered from FETCH. Go to IDLE.
- **COMPARE, miss**
  - The victim is way `lru`. Increment `miss_count`.
  - If `dirty<lru>` is set, go to WRITEBACK; otherwise go to FETCH.
- **WRITEBACK**
  - Assert `pmem_write`, with `way_sel`=`lru` and `pmem_addr_sel`=1.
  - On `pmem_resp`, go to FETCH.
- **FETCH**
  - Assert `pmem_read`, with `pmem_addr_sel`=0.
  - On `pmem_resp`, assert `load_data<lru>` (with `data_sel`=1), `load_tag<lru>`, `load_valid<lru>`, and `load_dirty<lru>` with `dirty_in`=0, all in that same cycle. Go to COMPARE.
- **Simultaneous `mem_read` and `mem_write`:** illegal; treated as a write.
- **Counters:** saturate at all-ones, with no wrap.
- **Refill hit:** a hit after a refill is counted only as the miss.

## Timing
- **Reset:** state goes to IDLE, both counters go to 0, and all outputs are 0 immediately, asynchronously.
  - Reset during WRITEBACK or FETCH abandons the pmem transaction; `pmem_*` drop at once.
- **Hit latency:** the request is seen in IDLE at cycle 0, and `mem_resp` pulses in cycle 1.
- **Clean miss:** `mem_resp` pulses 1 cycle after the `pmem_resp` that ends FETCH.
- **Dirty miss:** WRITEBACK precedes FETCH; the first possible `pmem_read` cycle is the cycle after the writeback `pmem_resp`.
- **Back-to-back requests:** upstream deasserts its request in the cycle after `mem_resp`. A new request seen in IDLE that cycle is accepted.
- **Array writes:** array and LRU loads occur at the rising edge ending the asserting cycle. The arrays read asynchronously, so the re-check in COMPARE sees the refilled line.
- **Stray `pmem_resp`:** ignored in IDLE and COMPARE.

## Structure
- Package `l2_types`:
  - state enum `l2_state_t`: IDLE, COMPARE, WRITEBACK, FETCH;
  - `DATA_SEL_UPSTREAM` = 0 and `DATA_SEL_PMEM` = 1;
  - `PADDR_REQ` = 0 and `PADDR_VICTIM` = 1.
- Sub-module `l2_sat_counter`: parameterised width, with `rst`, `inc` and `count`. Instantiate it twice, for hits and misses.

## Test plan
- **Reset then idle:** assert `rst` mid-cycle, then hold idle 5 cycles → all outputs are 0 at once; `hit_count`=`miss_count`=0.
- **Read hit:** `mem_read` with `hit1`=1 → `mem_resp` in cycle 1; `way_sel`=1, `load_lru`=1, `lru_in`=0; `hit_count`=1; no `pmem_*`.
- **Write hit:** `mem_write` with `hit0`=1 → in the resp cycle, `load_data0`=1, `data_sel`=0, `load_dirty0`=1, `dirty_in`=1; no `load_tag`.
- **Clean miss:** `lru`=1, `dirty1`=0, `pmem_resp` 3 cycles into FETCH → `pmem_read` with `pmem_addr_sel`=0.
  - Then `load_data1`, `load_tag1`, `load_valid1` and `load_dirty1` (`dirty_in`=0) in the `pmem_resp` cycle.
  - Then force `hit1` → `mem_resp` the next cycle; `miss_count`=1, `hit_count`=0.
- **Dirty miss:** `lru`=0, `dirty0`=1 → `pmem_write` with `way_sel`=0 and `pmem_addr_sel`=1 until `pmem_resp`; then `pmem_read`; finally `mem_resp`.
- **Saturation and mid-FETCH reset:** with `CNT_W`=2, 5 hits → `hit_count`=3. Then `rst` during FETCH → `pmem_read` is 0 immediately, and the block restarts in IDLE.

Source files
------------

// File: rtl/l2_cache_control_pkg.sv
// Shared types and constants for the L2 cache controller.
//   l2_state_t        : controller states (IDLE, COMPARE, WRITEBACK, FETCH)
//   DATA_SEL_*        : data array write source select encodings
//   PADDR_*           : physical memory address source select encodings
package l2_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } l2_state_t;

  localparam logic DATA_SEL_UPSTREAM = 1'b0;
  localparam logic DATA_SEL_PMEM     = 1'b1;

  localparam logic PADDR_REQ    = 1'b0;
  localparam logic PADDR_VICTIM = 1'b1;

endpackage

// File: rtl/l2_cache_control_sat_counter.sv
// Saturating up-counter used for the L2 hit/miss performance counters.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current value; holds at all-ones instead of wrapping
module l2_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way, 64-set L2 cache. Serves line requests from the
// L1 arbiter, writes back dirty victims, refills from physical memory and
// re-checks. Pure control: tag compare results come in, array load enables
// and datapath selects go out.
// Handshake: mem_read/mem_write are held by upstream until the one-cycle
// mem_resp pulse; pmem_read/pmem_write are held by this block until the
// one-cycle pmem_resp pulse. A pmem_resp outside WRITEBACK/FETCH is ignored.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   mem_read, mem_write      : upstream request (both set = write)
//   mem_resp                 : upstream completion pulse
//   hit0/1, dirty0/1, lru    : array lookups for the current index
//   pmem_resp                : physical memory completion pulse
//   pmem_read, pmem_write    : physical memory requests
//   load_*                   : per-way array write enables, LRU write enable
//   dirty_in, lru_in         : values written to the dirty / LRU arrays
//   data_sel, way_sel        : data source select, output way select
//   pmem_addr_sel            : 0 = request address, 1 = victim address
//   hit_count, miss_count    : saturating performance counters
//   dbg_state                : current FSM state, for observation
module l2_cache_control
  import l2_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             lru,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             load_data0,
  output logic             load_data1,
  output logic             load_tag0,
  output logic             load_tag1,
  output logic             load_valid0,
  output logic             load_valid1,
  output logic             load_dirty0,
  output logic             load_dirty1,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             lru_in,
  output logic             data_sel,
  output logic             way_sel,
  output logic             pmem_addr_sel,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output l2_state_t        dbg_state
);

  l2_state_t state, next_state;
  // Set only for the COMPARE cycle that follows a refill, so that the
  // re-check hit is not counted a second time.
  logic refill;

  logic hit, hit_way, victim_dirty, hit_inc, miss_inc;

  assign hit          = hit0 | hit1;
  assign hit_way      = ~hit0;           // way 0 wins when both hit
  assign victim_dirty = lru ? dirty1 : dirty0;
  assign hit_inc      = (state == COMPARE) && hit && !refill;
  assign miss_inc     = (state == COMPARE) && !hit;
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      refill <= 1'b0;
    end else begin
      state  <= next_state;
      refill <= (state == FETCH) && pmem_resp;
    end
  end

  always_comb begin
    next_state    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_data0    = 1'b0;
    load_data1    = 1'b0;
    load_tag0     = 1'b0;
    load_tag1     = 1'b0;
    load_valid0   = 1'b0;
    load_valid1   = 1'b0;
    load_dirty0   = 1'b0;
    load_dirty1   = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = DATA_SEL_UPSTREAM;
    way_sel       = 1'b0;
    pmem_addr_sel = PADDR_REQ;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) next_state = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          mem_resp   = 1'b1;
          way_sel    = hit_way;
          load_lru   = 1'b1;
          lru_in     = ~hit_way;
          if (mem_write) begin
            load_data0  = ~hit_way;
            load_data1  = hit_way;
            load_dirty0 = ~hit_way;
            load_dirty1 = hit_way;
            dirty_in    = 1'b1;
            data_sel    = DATA_SEL_UPSTREAM;
          end
          next_state = IDLE;
        end else begin
          next_state = victim_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        way_sel       = lru;
        pmem_addr_sel = PADDR_VICTIM;
        if (pmem_resp) next_state = FETCH;
      end
      FETCH: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = PADDR_REQ;
        if (pmem_resp) begin
          // Whole refill lands in the victim way at this edge.
          load_data0  = ~lru;
          load_data1  = lru;
          load_tag0   = ~lru;
          load_tag1   = lru;
          load_valid0 = ~lru;
          load_valid1 = lru;
          load_dirty0 = ~lru;
          load_dirty1 = lru;
          dirty_in    = 1'b0;
          data_sel    = DATA_SEL_PMEM;
          next_state  = COMPARE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  l2_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  l2_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control. Each scenario task applies inputs one
// cycle at a time and pushes the outputs the spec demands for that cycle;
// a negedge compare process pops and checks them together with the counters.
module tb_l2_cache_control;
  import l2_types::*;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int OW    = 17;

  typedef struct packed {
    logic mem_resp, pmem_read, pmem_write;
    logic ld0, ld1, lt0, lt1, lv0, lv1, ldy0, ldy1;
    logic dirty_in, load_lru, lru_in, data_sel, way_sel, paddr_sel;
  } outs_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic mem_read = 0, mem_write = 0, hit0 = 0, hit1 = 0;
  logic dirty0 = 0, dirty1 = 0, lru = 0, pmem_resp = 0;
  logic mem_resp, pmem_read, pmem_write;
  logic load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1;
  logic load_dirty0, load_dirty1, dirty_in, load_lru, lru_in, data_sel, way_sel;
  logic pmem_addr_sel;
  logic [CNT_W-1:0] hit_count, miss_count;
  l2_state_t dbg_state;

  l2_cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit0(hit0), .hit1(hit1), .dirty0(dirty0),
    .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1), .load_valid0(load_valid0),
    .load_valid1(load_valid1), .load_dirty0(load_dirty0),
    .load_dirty1(load_dirty1), .dirty_in(dirty_in), .load_lru(load_lru),
    .lru_in(lru_in), .data_sel(data_sel), .way_sel(way_sel),
    .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count),
    .miss_count(miss_count), .dbg_state(dbg_state)
  );

  outs_t act;
  assign act = {mem_resp, pmem_read, pmem_write, load_data0, load_data1,
                load_tag0, load_tag1, load_valid0, load_valid1, load_dirty0,
                load_dirty1, dirty_in, load_lru, lru_in, data_sel, way_sel,
                pmem_addr_sel};

  // scoreboard
  logic [OW-1:0] exp_q[$];
  string         nm_q[$];
  int n_hits = 0, n_misses = 0;
  int checks = 0, errs = 0;

  function automatic logic [CNT_W-1:0] sat(int n);
    return (n > MAXC) ? CNT_W'(MAXC) : CNT_W'(n);
  endfunction

  // expected-output models, straight from the per-state rules
  function automatic outs_t o_hit(bit way, bit wr);
    outs_t e = '0;
    e.mem_resp = 1; e.way_sel = way; e.load_lru = 1; e.lru_in = ~way;
    if (wr) begin
      if (way) begin e.ld1 = 1; e.ldy1 = 1; end
      else     begin e.ld0 = 1; e.ldy0 = 1; end
      e.dirty_in = 1; e.data_sel = 0;
    end
    return e;
  endfunction

  function automatic outs_t o_wb(bit way);
    outs_t e = '0;
    e.pmem_write = 1; e.way_sel = way; e.paddr_sel = 1;
    return e;
  endfunction

  function automatic outs_t o_fetch(bit way, bit done);
    outs_t e = '0;
    e.pmem_read = 1; e.paddr_sel = 0;
    if (done) begin
      if (way) begin e.ld1 = 1; e.lt1 = 1; e.lv1 = 1; e.ldy1 = 1; end
      else     begin e.ld0 = 1; e.lt0 = 1; e.lv0 = 1; e.ldy0 = 1; end
      e.data_sel = 1; e.dirty_in = 0;
    end
    return e;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      checks++;
      if (act !== e) begin
        errs++;
        $display("FAIL %s outs: got %h want %h", nm, act, e);
      end
      checks++;
      if (hit_count !== sat(n_hits)) begin
        errs++;
        $display("FAIL %s hit_count: got %0d want %0d", nm, hit_count, sat(n_hits));
      end
      checks++;
      if (miss_count !== sat(n_misses)) begin
        errs++;
        $display("FAIL %s miss_count: got %0d want %0d", nm, miss_count, sat(n_misses));
      end
    end
  end

  // driver tasks
  task automatic set_in(bit r, bit w, bit a0, bit a1, bit b0, bit b1, bit l, bit p);
    mem_read = r; mem_write = w; hit0 = a0; hit1 = a1;
    dirty0 = b0; dirty1 = b1; lru = l; pmem_resp = p;
  endtask

  // one cycle: inputs already applied; expected outputs queued for negedge
  task automatic cyc(outs_t e, bit ih, bit im, string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    if (ih) n_hits++;
    if (im) n_misses++;
  endtask

  task automatic pin(string nm, logic [CNT_W-1:0] a, logic [CNT_W-1:0] w);
    checks++;
    if (a !== w) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, a, w);
    end
  endtask

  // reset asserted mid-cycle; outputs and counters must clear at once
  task automatic rst_pulse(string nm);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act !== '0 || dbg_state !== IDLE) begin
      errs++;
      $display("FAIL %s outs_at_reset: got %h/%0d want 0/IDLE", nm, act, dbg_state);
    end
    pin({nm, "_hit_count"}, hit_count, '0);
    pin({nm, "_miss_count"}, miss_count, '0);
    n_hits = 0; n_misses = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_idle(bit stray, string nm);
    set_in(0, 0, 0, 0, 1, 1, 1, stray);
    cyc('0, 0, 0, nm);
  endtask

  task automatic do_hit(bit r, bit w, bit a0, bit a1, bit stray, string nm);
    bit l, d;
    l = 1'($urandom_range(0, 1));
    d = 1'($urandom_range(0, 1));
    set_in(r, w, a0, a1, d, ~d, l, 0);
    cyc('0, 0, 0, {nm, "_idle"});
    pmem_resp = stray;
    cyc(o_hit(a0 ? 1'b0 : 1'b1, w), 1, 0, {nm, "_cmp"});
  endtask

  // miss: victim way v; other way's dirty bit is the opposite to expose
  // a wrong victim choice
  task automatic miss_head(bit r, bit w, bit v, bit vd, string nm);
    set_in(r, w, 0, 0, v ? ~vd : vd, v ? vd : ~vd, v, 0);
    cyc('0, 0, 0, {nm, "_idle"});
    cyc('0, 0, 1, {nm, "_cmp_miss"});
  endtask

  task automatic do_miss(bit r, bit w, bit v, bit vd, int wb_wait, int f_wait, string nm);
    miss_head(r, w, v, vd, nm);
    if (vd) begin
      for (int i = 0; i < wb_wait; i++) cyc(o_wb(v), 0, 0, {nm, "_wb"});
      pmem_resp = 1;
      cyc(o_wb(v), 0, 0, {nm, "_wb_resp"});
      pmem_resp = 0;
    end
    for (int i = 0; i < f_wait; i++) cyc(o_fetch(v, 0), 0, 0, {nm, "_fetch"});
    pmem_resp = 1;
    cyc(o_fetch(v, 1), 0, 0, {nm, "_fetch_resp"});
    pmem_resp = 0;
    if (v) hit1 = 1; else hit0 = 1;
    cyc(o_hit(v, w), 0, 0, {nm, "_recheck"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    rst_pulse("reset_idle");
    for (int i = 0; i < 5; i++) do_idle(0, "idle");

    // read hit way 1, then write hit way 0 back-to-back
    do_hit(1, 0, 0, 1, 0, "read_hit");
    pin("read_hit_count", hit_count, 2'd1);
    do_hit(0, 1, 1, 0, 0, "write_hit");

    // clean miss on way 1, pmem_resp in the third FETCH cycle
    rst_pulse("reset_2");
    do_miss(1, 0, 1, 0, 0, 2, "clean_miss");
    pin("clean_miss_mcount", miss_count, 2'd1);
    pin("clean_miss_hcount", hit_count, 2'd0);

    // dirty misses: victim 0 read, victim 1 write
    do_miss(1, 0, 0, 1, 2, 1, "dirty_miss0");
    do_miss(0, 1, 1, 1, 0, 0, "dirty_miss1");
    pin("dirty_mcount", miss_count, 2'd3);

    // both ways hit -> way 0; stray pmem_resp in COMPARE and IDLE
    do_hit(1, 0, 1, 1, 1, "both_hit");
    do_idle(1, "stray_idle");
    // simultaneous read and write treated as write
    do_hit(1, 1, 0, 1, 0, "rw_hit");

    // counter saturation
    rst_pulse("reset_3");
    for (int i = 0; i < 5; i++) do_hit(1, 0, 0, 1, 0, "sat_hit");
    pin("sat_hit_count", hit_count, 2'd3);
    for (int i = 0; i < 4; i++) do_miss(1, 0, 0, 0, 0, 0, "sat_miss");
    pin("sat_miss_count", miss_count, 2'd3);

    // reset in the middle of FETCH, then restart from IDLE
    miss_head(1, 0, 1, 0, "abort");
    cyc(o_fetch(1, 0), 0, 0, "abort_fetch");
    rst_pulse("abort_reset");
    do_hit(1, 0, 1, 0, 0, "after_abort");
    pin("after_abort_hcount", hit_count, 2'd1);
    do_idle(0, "final_idle");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
